fetch_ctrl: RTL and testbench

Fetch sequencer for the Lagarto front end. It owns the fetch PC and drives L1 instruction-cache lookups. It pushes hit lines into the instruction queue under `full` back-pressure. On a miss it runs the line refill from memory over a req/ack beat handshake and writes the assembled line into the icache. Branch redirects are accepted at any time and take effect at the next safe point.

---
 rtl/fetch_ctrl.sv | 171 +++++++++++++++++
 tb/tb_fetch_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: drives icache lookups from the fetch PC, pushes hit lines into the
// instruction queue, and refills missing lines from memory beat by beat.
module fetch_ctrl #(
  parameter int unsigned          ADDR_SIZE = 32,
  parameter int unsigned          LINE_SIZE = 128,
  parameter int unsigned          BEAT_W    = 32,
  parameter logic [ADDR_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 redirect_i,
  input  logic [ADDR_SIZE-1:0] redirect_pc_i,
  output logic                 ic_re_o,
  output logic [ADDR_SIZE-1:0] ic_pc_o,
  input  logic                 ic_hit_i,
  input  logic [LINE_SIZE-1:0] ic_line_i,
  output logic                 ic_we_o,
  output logic [LINE_SIZE-1:0] ic_wline_o,
  output logic                 mem_req_o,
  output logic [ADDR_SIZE-1:0] mem_addr_o,
  input  logic                 mem_ack_i,
  input  logic [BEAT_W-1:0]    mem_data_i,
  output logic                 iq_wr_o,
  output logic [LINE_SIZE-1:0] iq_data_o,
  input  logic                 iq_full_i,
  output logic [15:0]          miss_cnt_o
);

  localparam int unsigned NBEATS = LINE_SIZE / BEAT_W;
  localparam int unsigned LB     = LINE_SIZE / 8;
  localparam int unsigned BEAT_B = BEAT_W / 8;
  localparam int unsigned BCNT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  localparam logic [ADDR_SIZE-1:0] ALIGN_MASK = ~ADDR_SIZE'(LB - 1);
  localparam logic [ADDR_SIZE-1:0] LINE_STEP  = ADDR_SIZE'(LB);
  localparam logic [ADDR_SIZE-1:0] BEAT_STEP  = ADDR_SIZE'(BEAT_B);
  localparam logic [BCNT_W-1:0]    LAST_BEAT  = BCNT_W'(NBEATS - 1);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_REFILL = 2'd1,
    S_WRITE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_SIZE-1:0] pc_q;
  logic [ADDR_SIZE-1:0] miss_line_q;
  logic [ADDR_SIZE-1:0] redir_pc_q;
  logic                 pend_redir_q;
  logic [BCNT_W-1:0]    beat_q;
  logic [LINE_SIZE-1:0] line_buf_q;
  logic [15:0]          miss_cnt_q;

  logic [ADDR_SIZE-1:0] redir_aligned;
  logic                 last_ack;

  assign redir_aligned = redirect_pc_i & ALIGN_MASK;
  assign last_ack      = mem_ack_i && (beat_q == LAST_BEAT);
  assign iq_data_o     = ic_line_i;
  assign miss_cnt_o    = miss_cnt_q;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and outputs; reset overrides every output
  always_comb begin
    state_d    = state_q;
    ic_re_o    = 1'b0;
    ic_pc_o    = pc_q;
    ic_we_o    = 1'b0;
    ic_wline_o = '0;
    mem_req_o  = 1'b0;
    mem_addr_o = '0;
    iq_wr_o    = 1'b0;

    unique case (state_q)
      S_RUN: begin
        ic_re_o = 1'b1;
        if (!redirect_i && ic_hit_i && !iq_full_i) begin
          iq_wr_o = 1'b1;
        end
        if (!redirect_i && !ic_hit_i) begin
          state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        mem_req_o  = 1'b1;
        mem_addr_o = miss_line_q + ADDR_SIZE'(beat_q) * BEAT_STEP;
        if (last_ack) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        ic_we_o    = 1'b1;
        ic_pc_o    = miss_line_q;
        ic_wline_o = line_buf_q;
        state_d    = S_RUN;
      end
      default: state_d = S_RUN;
    endcase

    if (rst_i) begin
      state_d    = S_RUN;
      ic_re_o    = 1'b0;
      ic_pc_o    = RESET_PC;
      ic_we_o    = 1'b0;
      ic_wline_o = '0;
      mem_req_o  = 1'b0;
      mem_addr_o = '0;
      iq_wr_o    = 1'b0;
    end
  end

  // Fetch PC, refill buffer, pending redirect and miss counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q         <= RESET_PC;
      miss_line_q  <= '0;
      redir_pc_q   <= '0;
      pend_redir_q <= 1'b0;
      beat_q       <= '0;
      line_buf_q   <= '0;
      miss_cnt_q   <= '0;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (redirect_i) begin
            pc_q <= redir_aligned;
          end else if (ic_hit_i) begin
            if (!iq_full_i) begin
              pc_q <= pc_q + LINE_STEP;
            end
          end else begin
            miss_line_q <= pc_q;
            beat_q      <= '0;
            if (miss_cnt_q != 16'hFFFF) begin
              miss_cnt_q <= miss_cnt_q + 16'd1;
            end
          end
        end
        S_REFILL: begin
          if (mem_ack_i) begin
            line_buf_q[int'(beat_q) * int'(BEAT_W) +: BEAT_W] <= mem_data_i;
            beat_q <= beat_q + BCNT_W'(1);
          end
          // Refill runs to completion; the newest redirect target is applied after WRITE
          if (redirect_i) begin
            pend_redir_q <= 1'b1;
            redir_pc_q   <= redir_aligned;
          end
        end
        S_WRITE: begin
          if (redirect_i) begin
            pc_q <= redir_aligned;
          end else if (pend_redir_q) begin
            pc_q <= redir_pc_q;
          end
          pend_redir_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios followed by random traffic, every cycle
// checked against a phase-counting reference model of the fetch sequencer.
module tb_fetch_ctrl;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         redirect_i;
  logic [31:0]  redirect_pc_i;
  logic         ic_re_o;
  logic [31:0]  ic_pc_o;
  logic         ic_hit_i;
  logic [127:0] ic_line_i;
  logic         ic_we_o;
  logic [127:0] ic_wline_o;
  logic         mem_req_o;
  logic [31:0]  mem_addr_o;
  logic         mem_ack_i;
  logic [31:0]  mem_data_i;
  logic         iq_wr_o;
  logic [127:0] iq_data_o;
  logic         iq_full_i;
  logic [15:0]  miss_cnt_o;

  int checks   = 0;
  int failures = 0;

  fetch_ctrl #(
    .ADDR_SIZE(32), .LINE_SIZE(128), .BEAT_W(32), .RESET_PC(32'h0)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .ic_re_o(ic_re_o), .ic_pc_o(ic_pc_o), .ic_hit_i(ic_hit_i), .ic_line_i(ic_line_i),
    .ic_we_o(ic_we_o), .ic_wline_o(ic_wline_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .iq_wr_o(iq_wr_o), .iq_data_o(iq_data_o), .iq_full_i(iq_full_i),
    .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk = ~clk;

  // Reference model: m_got < 0 means fetching, 0..3 beats collected, 4 means line ready to write
  logic [31:0] m_pc, m_line, m_target;
  logic        m_pend;
  int          m_got, m_cnt;
  logic [31:0] m_w [4];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_line = 32'h0; m_target = 32'h0; m_pend = 1'b0;
    m_got = -1; m_cnt = 0;
    for (int i = 0; i < 4; i++) m_w[i] = 32'h0;
  endtask

  task automatic model_update();
    if (rst_i) begin
      model_reset();
    end else if (m_got < 0) begin
      if (redirect_i) m_pc = redirect_pc_i & ~32'hF;
      else if (ic_hit_i) begin
        if (!iq_full_i) m_pc = m_pc + 32'd16;
      end else begin
        m_line = m_pc;
        m_got  = 0;
        if (m_cnt < 65535) m_cnt++;
      end
    end else if (m_got < 4) begin
      if (mem_ack_i) begin
        m_w[m_got] = mem_data_i;
        m_got++;
      end
      if (redirect_i) begin
        m_pend   = 1'b1;
        m_target = redirect_pc_i & ~32'hF;
      end
    end else begin
      if (redirect_i) m_pc = redirect_pc_i & ~32'hF;
      else if (m_pend) m_pc = m_target;
      m_pend = 1'b0;
      m_got  = -1;
    end
  endtask

  task automatic drive(input logic r, input logic h, input logic f, input logic a,
                       input logic [31:0] d, input logic rd, input logic [31:0] rp);
    rst_i = r; ic_hit_i = h; iq_full_i = f; mem_ack_i = a; mem_data_i = d;
    redirect_i = rd; redirect_pc_i = rp;
    ic_line_i = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Compare all outputs against the model on the falling edge
  task automatic settle();
    logic exp_wr;
    @(negedge clk);
    exp_wr = 1'b0;
    if (rst_i) begin
      check_eq("rst_re", ic_re_o, 0);
      check_eq("rst_we", ic_we_o, 0);
      check_eq("rst_req", mem_req_o, 0);
      check_eq("rst_wr", iq_wr_o, 0);
      check_eq("rst_pc", ic_pc_o, 0);
      check_eq("rst_addr", mem_addr_o, 0);
      check_eq("rst_wline", ic_wline_o, 0);
    end else begin
      if (m_got < 0) begin
        exp_wr = !redirect_i && ic_hit_i && !iq_full_i;
        check_eq("run_re", ic_re_o, 1);
        check_eq("run_pc", ic_pc_o, m_pc);
        check_eq("run_we", ic_we_o, 0);
        check_eq("run_req", mem_req_o, 0);
      end else if (m_got < 4) begin
        check_eq("ref_re", ic_re_o, 0);
        check_eq("ref_we", ic_we_o, 0);
        check_eq("ref_req", mem_req_o, 1);
        check_eq("ref_addr", mem_addr_o, m_line + 32'(4 * m_got));
      end else begin
        check_eq("wr_re", ic_re_o, 0);
        check_eq("wr_we", ic_we_o, 1);
        check_eq("wr_pc", ic_pc_o, m_line);
        check_eq("wr_wline", ic_wline_o, {m_w[3], m_w[2], m_w[1], m_w[0]});
        check_eq("wr_req", mem_req_o, 0);
      end
      check_eq("iq_wr", iq_wr_o, exp_wr);
      if (exp_wr) check_eq("iq_data", iq_data_o, ic_line_i);
      check_eq("miss_cnt", miss_cnt_o, 16'(m_cnt));
    end
  endtask

  task automatic advance();
    model_update();
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    drive(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin settle(); advance(); end

    // Streaming hits from reset
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0, 0, 0, 0);
      settle();
      check_eq("stream_pc", ic_pc_o, 32'(i * 16));
      check_eq("stream_push", iq_wr_o, 1);
      check_eq("stream_cnt", miss_cnt_o, 0);
      advance();
    end

    // Miss at 0x40 with an ack every cycle
    drive(0, 0, 0, 0, 0, 0, 0); settle(); advance();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 1, 32'hA + 32'(i), 0, 0);
      settle();
      check_eq("beat_addr", mem_addr_o, 32'h40 + 32'(4 * i));
      advance();
    end
    drive(0, 1, 0, 0, 0, 0, 0);
    settle();
    check_eq("fill_we", ic_we_o, 1);
    check_eq("fill_pc", ic_pc_o, 32'h40);
    check_eq("fill_line", ic_wline_o, 128'h0000000D_0000000C_0000000B_0000000A);
    advance();
    settle();
    check_eq("relook_push", iq_wr_o, 1);
    check_eq("relook_pc", ic_pc_o, 32'h40);
    check_eq("relook_cnt", miss_cnt_o, 1);
    advance();

    // Miss at 0x50 with an ack only every third cycle
    drive(0, 0, 0, 0, 0, 0, 0); settle(); advance();
    for (int k = 0; k < 12; k++) begin
      drive(0, 1, 0, (k % 3) == 2, $urandom, 0, 0);
      settle();
      check_eq("stall_req", mem_req_o, 1);
      check_eq("stall_addr", mem_addr_o, 32'h50 + 32'(4 * (k / 3)));
      check_eq("stall_no_we", ic_we_o, 0);
      advance();
    end
    drive(0, 1, 0, 0, 0, 0, 0);
    settle(); check_eq("stall_we", ic_we_o, 1); advance();
    for (int i = 0; i < 3; i++) begin settle(); advance(); end

    // Queue full on a hit at 0x80
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 1, 0, 0, 0, 0);
      settle();
      check_eq("full_no_push", iq_wr_o, 0);
      check_eq("full_pc", ic_pc_o, 32'h80);
      advance();
    end
    drive(0, 1, 0, 0, 0, 0, 0);
    settle();
    check_eq("unfull_push", iq_wr_o, 1);
    check_eq("unfull_pc", ic_pc_o, 32'h80);
    advance();

    // Miss at 0x90 with two redirects during the refill; last one wins
    drive(0, 0, 0, 0, 0, 0, 0); settle(); advance();
    drive(0, 1, 0, 1, 32'h11, 1, 32'h1234); settle(); advance();
    drive(0, 1, 0, 1, 32'h22, 0, 0); settle(); advance();
    drive(0, 1, 0, 1, 32'h33, 1, 32'h2000); settle(); advance();
    drive(0, 1, 0, 1, 32'h44, 0, 0); settle(); advance();
    drive(0, 1, 0, 0, 0, 0, 0);
    settle(); check_eq("redir_fill_we", ic_we_o, 1); advance();
    drive(0, 0, 0, 0, 0, 0, 0);
    settle();
    check_eq("redir_pc", ic_pc_o, 32'h2000);
    check_eq("redir_re", ic_re_o, 1);
    advance();

    // Reset in the middle of the refill of 0x2000
    drive(0, 1, 0, 0, 0, 0, 0); settle(); advance();
    drive(1, 1, 0, 1, 0, 0, 0); settle(); advance();
    drive(0, 1, 0, 1, 0, 0, 0);
    settle();
    check_eq("mid_rst_req", mem_req_o, 0);
    check_eq("mid_rst_we", ic_we_o, 0);
    check_eq("mid_rst_pc", ic_pc_o, 32'h0);
    check_eq("mid_rst_cnt", miss_cnt_o, 0);
    advance();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0,
            $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 19) == 0, $urandom);
      settle();
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
